// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage branch resolution logic.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLEZ = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BGEZ = 3'd5
  } btype_t;

  typedef struct packed {
    logic        branch;
    logic        pred;
    btype_t      btype;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [15:0] imm;
  } br_slot_t;

  // Fall-through skips the branch and its delay slot.
  localparam logic [31:0] DELAY_SLOT_BYTES = 32'd8;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition, target and fall-through for one issue slot.
module branch_cond_eval
  import branch_pkg::*;
(
  input  btype_t      btype,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic [15:0] imm,
  input  logic [31:0] pc,
  output logic        take,
  output logic [31:0] target,
  output logic [31:0] fallthrough
);

  logic a_zero;
  logic a_neg;

  assign a_zero = (srca == 32'd0);
  assign a_neg  = srca[31];

  always_comb begin
    take = 1'b0;
    case (btype)
      BR_BEQ:  take = (srca == srcb);
      BR_BNE:  take = (srca != srcb);
      BR_BLEZ: take = a_neg | a_zero;
      BR_BGTZ: take = ~a_neg & ~a_zero;
      BR_BLTZ: take = a_neg;
      BR_BGEZ: take = ~a_neg;
      default: take = 1'b0;
    endcase
  end

  assign target      = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  assign fallthrough = pc + DELAY_SLOT_BYTES;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves up to two E-stage branches, raises a held redirect on mispredict (one-cycle
// detect-to-valid, held until redir_ready) and returns registered predictor training pulses.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter bit          RESOLVE_SLOT2 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             branch1E,
  input  logic             branch2E,
  input  logic             pred_take1E,
  input  logic             pred_take2E,
  input  logic [2:0]       btype1E,
  input  logic [2:0]       btype2E,
  input  logic [31:0]      srca1E,
  input  logic [31:0]      srcb1E,
  input  logic [31:0]      srca2E,
  input  logic [31:0]      srcb2E,
  input  logic [15:0]      imm1E,
  input  logic [15:0]      imm2E,
  input  logic [31:0]      PcE,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic             flush_req,
  output logic             upd1_valid,
  output logic             upd2_valid,
  output logic [31:0]      upd1_pc,
  output logic [31:0]      upd2_pc,
  output logic             upd1_take,
  output logic             upd2_take,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  br_slot_t    s1, s2;
  logic [31:0] pc2;
  logic        take1, take2;
  logic [31:0] tgt1, tgt2, ft1, ft2;

  assign s1  = '{branch: branch1E, pred: pred_take1E, btype: btype_t'(btype1E),
                 srca: srca1E, srcb: srcb1E, imm: imm1E};
  assign s2  = '{branch: branch2E, pred: pred_take2E, btype: btype_t'(btype2E),
                 srca: srca2E, srcb: srcb2E, imm: imm2E};
  assign pc2 = PcE + 32'd4;

  branch_cond_eval u_eval1 (
    .btype(s1.btype), .srca(s1.srca), .srcb(s1.srcb), .imm(s1.imm), .pc(PcE),
    .take(take1), .target(tgt1), .fallthrough(ft1)
  );

  branch_cond_eval u_eval2 (
    .btype(s2.btype), .srca(s2.srca), .srcb(s2.srcb), .imm(s2.imm), .pc(pc2),
    .take(take2), .target(tgt2), .fallthrough(ft2)
  );

  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic             upd1_valid_q, upd2_valid_q;
  logic [31:0]      upd1_pc_q, upd2_pc_q, upd1_pc_d, upd2_pc_d;
  logic             upd1_take_q, upd2_take_q, upd1_take_d, upd2_take_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  logic       pending, v_e, act1, act2, mis1, mis2, det, upd2_d;
  logic [1:0] n_act;
  logic [CNT_W:0] bsum, msum;

  // While a redirect is outstanding the E bundle is on the wrong path.
  assign pending = redir_valid_q & ~redir_ready;
  assign v_e     = ~stallE & ~flushE & ~pending;
  assign act1    = s1.branch & v_e;
  assign act2    = s2.branch & v_e & RESOLVE_SLOT2;
  assign mis1    = act1 & (s1.pred != take1);
  assign mis2    = act2 & ~mis1 & (s2.pred != take2);
  assign det     = mis1 | mis2;
  assign upd2_d  = act2 & ~mis1;
  assign n_act   = {1'b0, act1} + {1'b0, act2};

  assign bsum = {1'b0, branch_cnt_q} + {{(CNT_W-1){1'b0}}, n_act};
  assign msum = {1'b0, mispred_cnt_q} + {{CNT_W{1'b0}}, det};

  always_comb begin
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    if (det) begin
      redir_valid_d = 1'b1;
      if (mis1) redir_pc_d = take1 ? tgt1 : ft1;
      else      redir_pc_d = take2 ? tgt2 : ft2;
    end else if (redir_valid_q & redir_ready) begin
      redir_valid_d = 1'b0;
      redir_pc_d    = 32'd0;
    end

    upd1_pc_d   = act1 ? PcE : upd1_pc_q;
    upd1_take_d = act1 ? take1 : upd1_take_q;
    upd2_pc_d   = upd2_d ? pc2 : upd2_pc_q;
    upd2_take_d = upd2_d ? take2 : upd2_take_q;

    branch_cnt_d  = bsum[CNT_W] ? {CNT_W{1'b1}} : bsum[CNT_W-1:0];
    mispred_cnt_d = msum[CNT_W] ? {CNT_W{1'b1}} : msum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      upd1_valid_q  <= 1'b0;
      upd2_valid_q  <= 1'b0;
      upd1_pc_q     <= 32'd0;
      upd2_pc_q     <= 32'd0;
      upd1_take_q   <= 1'b0;
      upd2_take_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      upd1_valid_q  <= act1;
      upd2_valid_q  <= upd2_d;
      upd1_pc_q     <= upd1_pc_d;
      upd2_pc_q     <= upd2_pc_d;
      upd1_take_q   <= upd1_take_d;
      upd2_take_q   <= upd2_take_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign flush_req   = det;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign upd1_valid  = upd1_valid_q;
  assign upd2_valid  = upd2_valid_q;
  assign upd1_pc     = upd1_pc_q;
  assign upd2_pc     = upd2_pc_q;
  assign upd1_take   = upd1_take_q;
  assign upd2_take   = upd2_take_q;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (4-bit counters so saturation is reachable).
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallE, flushE, branch1E, branch2E, pred_take1E, pred_take2E;
  logic [2:0]  btype1E, btype2E;
  logic [31:0] srca1E, srcb1E, srca2E, srcb2E, PcE;
  logic [15:0] imm1E, imm2E;
  logic        redir_valid, redir_ready, flush_req;
  logic [31:0] redir_pc, upd1_pc, upd2_pc;
  logic        upd1_valid, upd2_valid, upd1_take, upd2_take;
  logic [3:0]  branch_cnt, mispred_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  branch_resolve_unit #(.CNT_W(4), .RESOLVE_SLOT2(1'b1)) dut (
    .clk(clk), .rst(rst), .stallE(stallE), .flushE(flushE),
    .branch1E(branch1E), .branch2E(branch2E),
    .pred_take1E(pred_take1E), .pred_take2E(pred_take2E),
    .btype1E(btype1E), .btype2E(btype2E),
    .srca1E(srca1E), .srcb1E(srcb1E), .srca2E(srca2E), .srcb2E(srcb2E),
    .imm1E(imm1E), .imm2E(imm2E), .PcE(PcE),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
    .flush_req(flush_req),
    .upd1_valid(upd1_valid), .upd2_valid(upd2_valid),
    .upd1_pc(upd1_pc), .upd2_pc(upd2_pc),
    .upd1_take(upd1_take), .upd2_take(upd2_take),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    stallE = 0; flushE = 0; branch1E = 0; branch2E = 0;
    pred_take1E = 0; pred_take2E = 0; btype1E = 0; btype2E = 0;
    srca1E = 0; srcb1E = 0; srca2E = 0; srcb2E = 0;
    imm1E = 0; imm2E = 0; PcE = 0; redir_ready = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    #3;
    total_cnt++; if (redir_valid !== 1'b0) $display("FAIL rst_redir_valid: got %0h want 0", redir_valid); else pass_cnt++;
    total_cnt++; if (redir_pc !== 32'h0) $display("FAIL rst_redir_pc: got %0h want 0", redir_pc); else pass_cnt++;
    total_cnt++; if (upd1_valid !== 1'b0 || upd2_valid !== 1'b0) $display("FAIL rst_upd_valid: got %0h%0h want 00", upd1_valid, upd2_valid); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) $display("FAIL rst_counters: got %0h/%0h want 0/0", branch_cnt, mispred_cnt); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_beq_mispredict();
    do_reset();
    branch1E = 1; btype1E = 3'd0; srca1E = 5; srcb1E = 5; pred_take1E = 0;
    PcE = 32'h1000; imm1E = 16'h0004;
    #2;
    total_cnt++; if (flush_req !== 1'b1) $display("FAIL beq_flush_req: got %0h want 1", flush_req); else pass_cnt++;
    step(); branch1E = 0; #1;
    total_cnt++; if (redir_valid !== 1'b1) $display("FAIL beq_redir_valid: got %0h want 1", redir_valid); else pass_cnt++;
    total_cnt++; if (redir_pc !== 32'h1014) $display("FAIL beq_redir_pc: got %0h want 1014", redir_pc); else pass_cnt++;
    total_cnt++; if (upd1_valid !== 1'b1 || upd1_take !== 1'b1 || upd1_pc !== 32'h1000) $display("FAIL beq_upd1: got v%0h t%0h pc%0h want v1 t1 pc1000", upd1_valid, upd1_take, upd1_pc); else pass_cnt++;
    total_cnt++; if (mispred_cnt !== 4'd1 || branch_cnt !== 4'd1) $display("FAIL beq_counters: got %0h/%0h want 1/1", branch_cnt, mispred_cnt); else pass_cnt++;
    total_cnt++; if (flush_req !== 1'b0) $display("FAIL beq_flush_clear: got %0h want 0", flush_req); else pass_cnt++;
    redir_ready = 1;
    step();
    total_cnt++; if (redir_valid !== 1'b0 || upd1_valid !== 1'b0) $display("FAIL beq_accept: got v%0h upd%0h want 0 0", redir_valid, upd1_valid); else pass_cnt++;
    redir_ready = 0;
  endtask

  task automatic test_hold_redirect();
    do_reset();
    branch1E = 1; btype1E = 3'd1; srca1E = 32'h77; srcb1E = 32'h77; pred_take1E = 1;
    PcE = 32'h2000; imm1E = 16'h0010;
    #2;
    total_cnt++; if (flush_req !== 1'b1) $display("FAIL hold_flush_req: got %0h want 1", flush_req); else pass_cnt++;
    step();
    // correctly predicted not-taken beq arrives while the redirect waits
    btype1E = 3'd0; srca1E = 1; srcb1E = 2; pred_take1E = 0; PcE = 32'h2100;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h2008) $display("FAIL hold_stable_%0d: got v%0h pc%0h want v1 pc2008", i, redir_valid, redir_pc); else pass_cnt++;
      total_cnt++; if (flush_req !== 1'b0) $display("FAIL hold_no_flush_%0d: got %0h want 0", i, flush_req); else pass_cnt++;
      step();
    end
    total_cnt++; if (upd1_valid !== 1'b0) $display("FAIL hold_no_train: got %0h want 0", upd1_valid); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) $display("FAIL hold_counters: got %0h/%0h want 1/1", branch_cnt, mispred_cnt); else pass_cnt++;
    branch1E = 0; redir_ready = 1;
    step();
    total_cnt++; if (redir_valid !== 1'b0) $display("FAIL hold_release: got %0h want 0", redir_valid); else pass_cnt++;
    redir_ready = 0;
  endtask

  task automatic test_slot2_mispredict();
    do_reset();
    branch1E = 1; btype1E = 3'd3; srca1E = 32'hFFFF_FFFF; pred_take1E = 0;
    branch2E = 1; btype2E = 3'd4; srca2E = 32'hFFFF_FFFF; pred_take2E = 0;
    PcE = 32'h1000; imm1E = 16'h0020; imm2E = 16'h0010;
    #2;
    total_cnt++; if (flush_req !== 1'b1) $display("FAIL s2_flush_req: got %0h want 1", flush_req); else pass_cnt++;
    step(); branch1E = 0; branch2E = 0; #1;
    total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h1048) $display("FAIL s2_redir: got v%0h pc%0h want v1 pc1048", redir_valid, redir_pc); else pass_cnt++;
    total_cnt++; if (upd1_valid !== 1'b1 || upd2_valid !== 1'b1) $display("FAIL s2_upd_valid: got %0h%0h want 11", upd1_valid, upd2_valid); else pass_cnt++;
    total_cnt++; if (upd1_take !== 1'b0 || upd2_take !== 1'b1 || upd2_pc !== 32'h1004) $display("FAIL s2_upd_data: got t1=%0h t2=%0h pc2=%0h want 0 1 1004", upd1_take, upd2_take, upd2_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 4'd2 || mispred_cnt !== 4'd1) $display("FAIL s2_counters: got %0h/%0h want 2/1", branch_cnt, mispred_cnt); else pass_cnt++;
  endtask

  task automatic test_both_mispredict();
    do_reset();
    branch1E = 1; btype1E = 3'd0; srca1E = 9; srcb1E = 9; pred_take1E = 0;
    branch2E = 1; btype2E = 3'd5; srca2E = 0; pred_take2E = 0;
    PcE = 32'h3000; imm1E = 16'hFFFF; imm2E = 16'h0100;
    #2;
    step(); branch1E = 0; branch2E = 0; #1;
    total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h3000) $display("FAIL both_redir: got v%0h pc%0h want v1 pc3000", redir_valid, redir_pc); else pass_cnt++;
    total_cnt++; if (upd1_valid !== 1'b1 || upd2_valid !== 1'b0) $display("FAIL both_upd_valid: got %0h%0h want 10", upd1_valid, upd2_valid); else pass_cnt++;
    total_cnt++; if (mispred_cnt !== 4'd1) $display("FAIL both_mispred_cnt: got %0h want 1", mispred_cnt); else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    stallE = 1;
    branch1E = 1; btype1E = 3'd0; srca1E = 3; srcb1E = 3; pred_take1E = 0;
    PcE = 32'h4000; imm1E = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      #2;
      total_cnt++; if (flush_req !== 1'b0) $display("FAIL stall_flush_%0d: got %0h want 0", i, flush_req); else pass_cnt++;
      step();
      total_cnt++; if (upd1_valid !== 1'b0 || redir_valid !== 1'b0) $display("FAIL stall_quiet_%0d: got upd%0h redir%0h want 0 0", i, upd1_valid, redir_valid); else pass_cnt++;
    end
    stallE = 0;
    #2;
    total_cnt++; if (flush_req !== 1'b1) $display("FAIL stall_release_flush: got %0h want 1", flush_req); else pass_cnt++;
    step(); branch1E = 0; #1;
    total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h4004) $display("FAIL stall_redir: got v%0h pc%0h want v1 pc4004", redir_valid, redir_pc); else pass_cnt++;
    step();
    total_cnt++; if (upd1_valid !== 1'b0 || mispred_cnt !== 4'd1 || branch_cnt !== 4'd1) $display("FAIL stall_single_event: got upd%0h m%0h b%0h want 0 1 1", upd1_valid, mispred_cnt, branch_cnt); else pass_cnt++;
  endtask

  task automatic test_saturation_and_reset();
    do_reset();
    redir_ready = 1;
    branch1E = 1; btype1E = 3'd0; srca1E = 4; srcb1E = 4; pred_take1E = 0;
    branch2E = 1; btype2E = 3'd1; srca2E = 1; srcb2E = 2; pred_take2E = 1;
    PcE = 32'h5000; imm1E = 16'h0000;
    for (int i = 0; i < 17; i++) step();
    // each cycle is an accept plus a new detection, so the redirect is reloaded
    total_cnt++; if (redir_valid !== 1'b1 || redir_pc !== 32'h5004) $display("FAIL sat_reload: got v%0h pc%0h want v1 pc5004", redir_valid, redir_pc); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 4'hF) $display("FAIL sat_branch_cnt: got %0h want f", branch_cnt); else pass_cnt++;
    total_cnt++; if (mispred_cnt !== 4'hF) $display("FAIL sat_mispred_cnt: got %0h want f", mispred_cnt); else pass_cnt++;
    #2 rst = 0;
    #1;
    total_cnt++; if (redir_valid !== 1'b0 || redir_pc !== 32'h0) $display("FAIL arst_redir: got v%0h pc%0h want 0 0", redir_valid, redir_pc); else pass_cnt++;
    total_cnt++; if (upd1_valid !== 1'b0 || upd1_pc !== 32'h0 || upd1_take !== 1'b0) $display("FAIL arst_upd1: got v%0h pc%0h t%0h want 0 0 0", upd1_valid, upd1_pc, upd1_take); else pass_cnt++;
    total_cnt++; if (branch_cnt !== 4'h0 || mispred_cnt !== 4'h0) $display("FAIL arst_counters: got %0h/%0h want 0/0", branch_cnt, mispred_cnt); else pass_cnt++;
    clear_inputs();
    step();
    rst = 1;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_beq_mispredict();
    test_hold_redirect();
    test_slot2_mispredict();
    test_both_mispredict();
    test_stall();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
